// File: rtl/wave_gen_mc.sv
// wave_gen_mc: multi-channel waveform generator.
//
// A loadable prescaler produces a sample strobe (tick_o). Every channel owns a
// phase accumulator, an LFSR noise source and a shadowed function/phase/amp
// configuration that only switches at the channel's accumulator wrap, so a
// running waveform never glitches mid-cycle.
//
// Ports
//   clock_i     system clock, all state on the rising edge
//   rst_i       asynchronous active-high reset
//   ld_i        load prescaler period and counter from pl_i
//   pl_i        prescaler reload value
//   func_i      per-channel function select, channel c at [3c+2:3c]
//   phase_i     per-channel quarter-turn phase offset, channel c at [2c+1:2c]
//   amp_i       per-channel attenuation (right shift 0..3), channel c at [2c+1:2c]
//   tick_o      prescaler terminal pulse (sample strobe)
//   cnt_out_o   prescaler counter value
//   wave_out_o  registered samples, channel c at [W(c+1)-1:Wc]
//   sync_o      one-cycle pulse per channel accumulator wrap

// Per-channel datapath: accumulator, LFSR, shadow config and sample shaper.
module wave_gen_ch #(
    parameter int            W    = 8,
    parameter int            CH   = 0,
    parameter logic [W-1:0]  TAPS = 8'hB8
) (
    input  logic         clock_i,
    input  logic         rst_i,
    input  logic         tick_i,
    input  logic [2:0]   func_i,
    input  logic [1:0]   phase_i,
    input  logic [1:0]   amp_i,
    output logic [W-1:0] wave_o,
    output logic         sync_o
);
    typedef struct packed {
        logic [2:0] f;
        logic [1:0] ph;
        logic [1:0] a;
    } cfg_t;

    localparam logic [W-1:0] SEED = W'(CH + 1);

    cfg_t         cfg_q, cfg_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] lfsr_q, lfsr_d;
    logic [W-1:0] wave_q, wave_d;
    logic [W-1:0] p;
    logic [W-1:0] s;
    logic [W-1:0] tri_v;
    logic         load;

    assign sync_o = tick_i & (&acc_q);
    // An idle channel (func 000) follows its inputs every cycle; a running one
    // only takes new settings on its wrap.
    assign load   = sync_o | (cfg_q.f == 3'b000);
    assign p      = acc_q + {cfg_q.ph, {(W-2){1'b0}}};
    assign tri_v  = p[W-1] ? ~{p[W-2:0], 1'b0} : {p[W-2:0], 1'b0};

    always_comb begin
        s = '0;
        unique case (cfg_q.f)
            3'b000: s = '0;
            3'b001: s = p;
            3'b010: s = ~p;
            3'b011: s = tri_v;
            3'b100: s = {W{~p[W-1]}};
            3'b101: s = {W{p[W-1:W-2] == 2'b00}};
            3'b110: s = {p[W-1:W/2], {(W/2){1'b0}}};
            3'b111: s = lfsr_q;
            default: s = '0;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        lfsr_d = lfsr_q;
        cfg_d  = cfg_q;
        if (tick_i) begin
            acc_d  = acc_q + 1'b1;
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        end
        if (load) begin
            cfg_d.f  = func_i;
            cfg_d.ph = phase_i;
            cfg_d.a  = amp_i;
        end
        wave_d = s >> cfg_q.a;
    end

    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q  <= '0;
            acc_q  <= '0;
            lfsr_q <= SEED;
            wave_q <= '0;
        end else begin
            cfg_q  <= cfg_d;
            acc_q  <= acc_d;
            lfsr_q <= lfsr_d;
            wave_q <= wave_d;
        end
    end

    assign wave_o = wave_q;
endmodule

module wave_gen_mc #(
    parameter int            W         = 8,
    parameter int            N_CH      = 2,
    parameter int            DIV_W     = 9,
    parameter logic [W-1:0]  LFSR_TAPS = 8'hB8
) (
    input  logic                clock_i,
    input  logic                rst_i,
    input  logic                ld_i,
    input  logic [DIV_W-1:0]    pl_i,
    input  logic [3*N_CH-1:0]   func_i,
    input  logic [2*N_CH-1:0]   phase_i,
    input  logic [2*N_CH-1:0]   amp_i,
    output logic                tick_o,
    output logic [DIV_W-1:0]    cnt_out_o,
    output logic [W*N_CH-1:0]   wave_out_o,
    output logic [N_CH-1:0]     sync_o
);
    logic [DIV_W-1:0]           cnt_q, cnt_d;
    logic [DIV_W-1:0]           pl_q, pl_d;
    logic [N_CH-1:0][W-1:0]     wave;

    // A load on the terminal count wins: it reloads and swallows the tick.
    assign tick_o    = (&cnt_q) & ~ld_i;
    assign cnt_out_o = cnt_q;

    always_comb begin
        pl_d  = pl_q;
        cnt_d = cnt_q;
        if (ld_i) begin
            pl_d  = pl_i;
            cnt_d = pl_i;
        end else if (&cnt_q) begin
            cnt_d = pl_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            pl_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            pl_q  <= pl_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        wave_gen_ch #(
            .W    (W),
            .CH   (c),
            .TAPS (LFSR_TAPS)
        ) u_ch (
            .clock_i (clock_i),
            .rst_i   (rst_i),
            .tick_i  (tick_o),
            .func_i  (func_i[3*c +: 3]),
            .phase_i (phase_i[2*c +: 2]),
            .amp_i   (amp_i[2*c +: 2]),
            .wave_o  (wave[c]),
            .sync_o  (sync_o[c])
        );
    end

    assign wave_out_o = wave;
endmodule

// File: tb/tb_wave_gen_mc.sv
module tb_wave_gen_mc;
    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        ld    = 1'b0;
    logic [8:0]  pl    = '0;
    logic [5:0]  func  = '0;
    logic [3:0]  phase = '0;
    logic [3:0]  amp   = '0;
    logic        tick;
    logic [8:0]  cnt_out;
    logic [15:0] wave_out;
    logic [1:0]  sync;

    int n_vec = 0;
    int n_err = 0;

    wave_gen_mc dut (
        .clock_i    (clock),
        .rst_i      (rst),
        .ld_i       (ld),
        .pl_i       (pl),
        .func_i     (func),
        .phase_i    (phase),
        .amp_i      (amp),
        .tick_o     (tick),
        .cnt_out_o  (cnt_out),
        .wave_out_o (wave_out),
        .sync_o     (sync)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] f;
        logic [1:0] ph;
        logic [1:0] am;
        int         ch;
        int         a;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[27];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int w_of(input int ch);
        return int'(wave_out[8*ch +: 8]);
    endfunction

    function automatic logic [7:0] tri8(input logic [7:0] p);
        logic [7:0] t;
        t = {p[6:0], 1'b0};
        return p[7] ? ~t : t;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ld = 1'b0; pl = '0; func = '0; phase = '0; amp = '0;
        step();
        rst = 1'b0;
    endtask

    // Reset, then load pl=1FF (tick every cycle) with the channel configured.
    // After edge n (n>=2) the sample for acc=n-2 is on wave_out.
    task automatic start_run(input int ch, input logic [2:0] f,
                             input logic [1:0] ph, input logic [1:0] am);
        do_reset();
        func[3*ch +: 3]  = f;
        phase[2*ch +: 2] = ph;
        amp[2*ch +: 2]   = am;
        ld = 1'b1;
        pl = 9'h1FF;
        step();
        ld = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        start_run(v.ch, v.f, v.ph, v.am);
        repeat (v.a + 1) step();
        nm = $sformatf("vec%0d_ch%0d", idx, v.ch);
        chk(nm, w_of(v.ch), int'(v.exp));
        chk({nm, "_other"}, w_of(1 - v.ch), 0);
    endtask

    initial begin
        int i;
        int found;
        vt[0]  = '{3'b001, 2'd0, 2'd0, 0, 8'h00, 8'h00};
        vt[1]  = '{3'b001, 2'd0, 2'd0, 0, 8'h37, 8'h37};
        vt[2]  = '{3'b001, 2'd0, 2'd0, 0, 8'hFF, 8'hFF};
        vt[3]  = '{3'b010, 2'd0, 2'd0, 0, 8'h10, 8'hEF};
        vt[4]  = '{3'b011, 2'd1, 2'd0, 0, 8'h00, 8'h80};
        vt[5]  = '{3'b011, 2'd1, 2'd0, 0, 8'h3F, 8'hFE};
        vt[6]  = '{3'b011, 2'd1, 2'd0, 0, 8'h40, 8'hFF};
        vt[7]  = '{3'b011, 2'd1, 2'd0, 0, 8'h80, 8'h7F};
        vt[8]  = '{3'b100, 2'd0, 2'd3, 1, 8'h10, 8'h1F};
        vt[9]  = '{3'b100, 2'd0, 2'd3, 1, 8'h7F, 8'h1F};
        vt[10] = '{3'b100, 2'd0, 2'd3, 1, 8'h90, 8'h00};
        vt[11] = '{3'b101, 2'd0, 2'd0, 1, 8'h3F, 8'hFF};
        vt[12] = '{3'b101, 2'd0, 2'd0, 1, 8'h40, 8'h00};
        vt[13] = '{3'b101, 2'd3, 2'd0, 1, 8'h40, 8'hFF};
        vt[14] = '{3'b110, 2'd0, 2'd0, 0, 8'h37, 8'h30};
        vt[15] = '{3'b110, 2'd0, 2'd1, 0, 8'hE5, 8'h70};
        vt[16] = '{3'b001, 2'd0, 2'd2, 1, 8'hFF, 8'h3F};
        vt[17] = '{3'b111, 2'd2, 2'd0, 0, 0, 8'h01};
        vt[18] = '{3'b111, 2'd0, 2'd0, 0, 1, 8'hB8};
        vt[19] = '{3'b111, 2'd0, 2'd0, 0, 2, 8'h5C};
        vt[20] = '{3'b111, 2'd0, 2'd0, 0, 3, 8'h2E};
        vt[21] = '{3'b111, 2'd0, 2'd0, 0, 4, 8'h17};
        vt[22] = '{3'b111, 2'd0, 2'd0, 0, 5, 8'hB3};
        vt[23] = '{3'b111, 2'd0, 2'd0, 1, 0, 8'h02};
        vt[24] = '{3'b111, 2'd0, 2'd0, 1, 1, 8'h01};
        vt[25] = '{3'b111, 2'd0, 2'd0, 1, 2, 8'hB8};
        vt[26] = '{3'b000, 2'd0, 2'd0, 0, 8'h20, 8'h00};

        // Table-driven samples.
        for (int k = 0; k < 27; k++) run_vec(vt[k], k);

        // Ramp on ch0 with continuous tick, across the wrap.
        start_run(0, 3'b001, 2'd0, 2'd0);
        for (int n = 2; n <= 260; n++) begin
            step();
            chk($sformatf("ramp_tick_n%0d", n), int'(tick), 1);
            chk($sformatf("ramp_wave_n%0d", n), w_of(0), (n - 2) & 8'hFF);
            chk($sformatf("ramp_sync_n%0d", n), int'(sync[0]),
                (((n - 1) & 8'hFF) == 8'hFF) ? 1 : 0);
        end

        // Asynchronous reset mid-run, then default period.
        #2 rst = 1'b1;
        func = '0;
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_cnt", int'(cnt_out), 0);
        chk("rst_wave", int'(wave_out), 0);
        chk("rst_sync", int'(sync), 0);
        #1 rst = 1'b0;
        found = 0;
        i = 0;
        while (i < 600 && !found) begin
            step();
            i++;
            if (tick) found = 1;
        end
        chk("first_tick_cycles", i, 511);
        found = 0;
        i = 0;
        while (i < 600 && !found) begin
            step();
            i++;
            if (tick) found = 1;
        end
        chk("tick_period", i, 512);

        // Triangle with shadowed phase changes: nothing moves until the wrap,
        // and the last value written before the wrap is the one that applies.
        start_run(0, 3'b011, 2'd0, 2'd0);
        for (int n = 2; n <= 260; n++) begin
            step();
            chk($sformatf("shadow_n%0d", n), w_of(0),
                int'(tri8(8'((n - 2) & 8'hFF) + ((n >= 258) ? 8'h40 : 8'h00))));
            if (n == 8'h11) phase[1:0] = 2'd2;
            if (n == 8'h81) phase[1:0] = 2'd1;
        end

        // ld on the terminal count: no tick, acc holds, then period 2.
        do_reset();
        func[2:0] = 3'b001;
        ld = 1'b1;
        pl = 9'h1F0;
        step();
        ld = 1'b0;
        found = 0;
        i = 0;
        while (i < 40 && !found) begin
            if (cnt_out == 9'h1FF) found = 1;
            else begin
                chk("pre_coll_tick", int'(tick), 0);
                step();
                i++;
            end
        end
        chk("coll_reached", found, 1);
        ld = 1'b1;
        pl = 9'h1FE;
        #1;
        chk("coll_tick", int'(tick), 0);
        step();
        ld = 1'b0;
        chk("coll_cnt", int'(cnt_out), 9'h1FE);
        chk("t1_tick", int'(tick), 0);
        step();
        chk("t2_tick", int'(tick), 1);
        chk("t2_wave", w_of(0), 0);
        step();
        chk("t3_tick", int'(tick), 0);
        chk("t3_wave", w_of(0), 0);
        step();
        chk("t4_tick", int'(tick), 1);
        chk("t4_wave", w_of(0), 1);
        step();
        chk("t5_tick", int'(tick), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
